clock_gate_ctrl: RTL and testbench

CLOCK_GATE_CTRL -- requirements
Module: clock_gate_ctrl

---
 rtl/clock_gate_pkg.sv | 13 +
 rtl/clock_gate_ch.sv | 73 +++++++
 rtl/clock_gate_ctrl.sv | 45 ++++
 tb/tb_clock_gate_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_gate_pkg.sv
// Shared types and constants for the clock-gating controller and its channels.
package clock_gate_pkg;

  typedef enum logic [1:0] {
    CG_OFF,
    CG_WAKE,
    CG_ON,
    CG_IDLE
  } cg_state_t;

  localparam int unsigned WAKE_CNT_W = 4;

endpackage

// File: rtl/clock_gate_ch.sv
// One gated-clock channel: OFF/WAKE/ON/IDLE FSM with wake and idle counters.
module clock_gate_ch
  import clock_gate_pkg::*;
#(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              active,
  input  logic [IDLE_W-1:0] idle_thr,
  output logic              en,
  output logic              ack
);

  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYC - 1);

  cg_state_t             state, state_n;
  logic [WAKE_CNT_W-1:0] wake_cnt, wake_cnt_n;
  logic [IDLE_W-1:0]     idle_cnt, idle_cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CG_OFF;
      wake_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_n;
      wake_cnt <= wake_cnt_n;
      idle_cnt <= idle_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    wake_cnt_n = '0;
    idle_cnt_n = '0;
    unique case (state)
      CG_OFF: begin
        if (active) state_n = CG_WAKE;
      end
      // Wake runs to completion regardless of further activity.
      CG_WAKE: begin
        if (wake_cnt == WAKE_LAST) state_n = CG_ON;
        else                       wake_cnt_n = wake_cnt + 1'b1;
      end
      CG_ON: begin
        if (!active) begin
          if (idle_thr == '0) begin
            state_n = CG_OFF;
          end else begin
            state_n    = CG_IDLE;
            idle_cnt_n = IDLE_W'(1);
          end
        end
      end
      CG_IDLE: begin
        if (active) begin
          state_n = CG_ON;
        end else if (idle_cnt >= idle_thr) begin
          state_n = CG_OFF;
        end else begin
          idle_cnt_n = (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;
        end
      end
      default: state_n = CG_OFF;
    endcase
  end

  assign en  = (state != CG_OFF);
  assign ack = (state == CG_ON) || (state == CG_IDLE);

endmodule

// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock-gate controller: one independent channel FSM per gating cell.
module clock_gate_ctrl
  import clock_gate_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              test_en_i,
  input  logic [N_CH-1:0]   cfg_auto_i,
  input  logic [N_CH-1:0]   cfg_force_on_i,
  input  logic [IDLE_W-1:0] cfg_idle_thr_i,
  input  logic [N_CH-1:0]   req_i,
  input  logic [N_CH-1:0]   busy_i,
  output logic [N_CH-1:0]   en_o,
  output logic [N_CH-1:0]   ack_o,
  output logic              any_on_o
);

  logic [N_CH-1:0] active;
  logic [N_CH-1:0] state_en;

  assign active = req_i | busy_i | cfg_force_on_i | ~cfg_auto_i;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    clock_gate_ch #(
      .IDLE_W   (IDLE_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_ch (
      .clk      (clk_i),
      .rst      (rst_i),
      .active   (active[g]),
      .idle_thr (cfg_idle_thr_i),
      .en       (state_en[g]),
      .ack      (ack_o[g])
    );
  end

  // Test override only touches the output, never channel state.
  assign en_o     = state_en | {N_CH{test_en_i}};
  assign any_on_o = |state_en;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Scoreboard bench for clock_gate_ctrl: reference model pushes expectations, outputs popped after each edge.
module tb_clock_gate_ctrl;

  localparam int N    = 4;
  localparam int IW   = 8;
  localparam int WCYC = 2;
  localparam int SAT  = 255;

  logic          clk = 1'b0;
  logic          rst, test_en;
  logic [N-1:0]  auto_v, force_v, req, busy;
  logic [IW-1:0] thr;
  logic [N-1:0]  en, ack;
  logic          any_on;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [N-1:0] en;
    logic [N-1:0] ack;
    logic         any;
  } exp_t;
  exp_t sb[$];

  // model state: 0=OFF 1=WAKE 2=ON 3=IDLE
  int ms[N];
  int mw[N];
  int mi[N];

  always #5 clk = ~clk;

  clock_gate_ctrl #(
    .N_CH     (N),
    .IDLE_W   (IW),
    .WAKE_CYC (WCYC)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .test_en_i      (test_en),
    .cfg_auto_i     (auto_v),
    .cfg_force_on_i (force_v),
    .cfg_idle_thr_i (thr),
    .req_i          (req),
    .busy_i         (busy),
    .en_o           (en),
    .ack_o          (ack),
    .any_on_o       (any_on)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_advance();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      bit act;
      act = req[i] | busy[i] | force_v[i] | ~auto_v[i];
      if (rst) begin
        ms[i] = 0; mw[i] = 0; mi[i] = 0;
      end else begin
        case (ms[i])
          0: if (act) begin ms[i] = 1; mw[i] = 0; end
          1: begin
            if (mw[i] + 1 >= WCYC) begin ms[i] = 2; mi[i] = 0; end
            else mw[i]++;
          end
          2: if (!act) begin
            if (thr == 0) ms[i] = 0;
            else begin ms[i] = 3; mi[i] = 1; end
          end
          default: begin
            if (act) begin ms[i] = 2; mi[i] = 0; end
            else if (mi[i] >= int'(thr)) ms[i] = 0;
            else if (mi[i] < SAT) mi[i]++;
          end
        endcase
      end
    end
    e.any = 1'b0;
    for (int i = 0; i < N; i++) begin
      e.en[i]  = (ms[i] != 0) | test_en;
      e.ack[i] = (ms[i] >= 2);
      e.any    = e.any | (ms[i] != 0);
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_advance();
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("sb_en", en, e.en);
      check("sb_ack", ack, e.ack);
      check("sb_any", any_on, e.any);
    end
  endtask

  task automatic wake0();
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    repeat (WCYC) step();
  endtask

  initial begin
    rst = 1'b1; test_en = 1'b0; auto_v = '1; force_v = '0;
    req = '0; busy = '0; thr = 8'd3;
    for (int i = 0; i < N; i++) begin ms[i] = 0; mw[i] = 0; mi[i] = 0; end
    repeat (2) step();
    check("reset_en", en, 4'h0);
    check("reset_ack", ack, 4'h0);
    check("reset_any", any_on, 1'b0);
    rst = 1'b0;
    step();

    // wake latency
    req[0] = 1'b1;
    step();
    check("wake_en", en[0], 1'b1);
    check("wake_ack_early", ack[0], 1'b0);
    req[0] = 1'b0;
    step();
    check("wake_ack_mid", ack[0], 1'b0);
    step();
    check("wake_ack", ack[0], 1'b1);

    // auto-gate, thr=3
    repeat (3) step();
    check("autogate_hold", en[0], 1'b1);
    step();
    check("autogate_off", en[0], 1'b0);

    // re-activation from IDLE with counter at 3
    thr = 8'd5;
    wake0();
    repeat (3) step();
    busy[0] = 1'b1;
    step();
    check("react_on", ack[0] & en[0], 1'b1);
    busy[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check("react_en", en[0], 1'b1);
    end
    step();
    check("react_off", en[0], 1'b0);

    // thr=0 gates straight from ON
    thr = 8'd0;
    wake0();
    check("thr0_on", en[0], 1'b1);
    step();
    check("thr0_off", en[0], 1'b0);

    // threshold lowered mid-IDLE
    thr = 8'd200;
    wake0();
    repeat (10) step();
    check("thr_lower_hold", en[0], 1'b1);
    thr = 8'd2;
    step();
    check("thr_lower_off", en[0], 1'b0);

    // saturation at 255
    thr = 8'd255;
    wake0();
    repeat (255) step();
    check("thr_max_hold", en[0], 1'b1);
    step();
    check("thr_max_off", en[0], 1'b0);
    repeat (44) step();
    check("thr_max_stay", en[0], 1'b0);

    // reset mid-WAKE, then an unclocked channel wakes first cycle after reset
    thr = 8'd3;
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    rst = 1'b1;
    auto_v[1] = 1'b0;
    step();
    check("rst_wake_en", en[0], 1'b0);
    check("rst_wake_ack", ack[0], 1'b0);
    rst = 1'b0;
    step();
    check("post_rst_wake", en[1], 1'b1);
    auto_v = '1;
    rst = 1'b1;
    step();
    rst = 1'b0;

    // test override with all channels OFF
    test_en = 1'b1;
    #1;
    check("test_en_comb", en, 4'hF);
    repeat (3) step();
    check("test_ack", ack, 4'h0);
    check("test_any", any_on, 1'b0);
    test_en = 1'b0;
    #1;
    check("test_release", en, 4'h0);

    // random multi-channel traffic
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 59) == 0);
      test_en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) auto_v  = N'($urandom_range(0, 15)) | 4'hC;
      if ($urandom_range(0, 19) == 0) force_v = N'($urandom_range(0, 15)) & 4'h5;
      if ($urandom_range(0, 15) == 0) thr     = IW'($urandom_range(0, 6));
      for (int i = 0; i < N; i++) begin
        req[i]  = ($urandom_range(0, 7) == 0);
        busy[i] = ($urandom_range(0, 9) == 0);
      end
      step();
    end

    check("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
